wb_regfile_unit: RTL and testbench

//  Write-back stage plus architectural register file: consumes MEM/WB pipeline-register outputs,

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/regfile_2r1w.sv | 50 +++++
 rtl/wb_regfile_unit.sv | 76 +++++++
 tb/tb_wb_regfile_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU widths and constants for the write-back / register-file slice.
// Pure declarations; no logic, no latency.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = $clog2(NREGS);
  localparam int CNT_W      = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xdata_t;

  // A write retires only when the pipeline is running and the target is not r0.
  function automatic logic commit_ok(input logic en, input logic we, input reg_addr_t addr);
    return en & we & (addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register storage: one write port, three combinational read ports, r0 hardwired to zero.
// Reads 0-cycle; a write lands on the clock edge and is visible the following cycle. No backpressure.
module regfile_2r1w
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  input  logic [REG_ADDR_W-1:0] raddr_c,
  output logic [XLEN-1:0]       rdata_a,
  output logic [XLEN-1:0]       rdata_b,
  output logic [XLEN-1:0]       rdata_c
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  // we is evaluated first so an unknown waddr with we low cannot select an entry.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (we && (waddr == REG_ADDR_W'(i)) && (i != 0)) begin
        regs_d[i] = wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    rdata_a = (raddr_a == REG_ZERO) ? '0 : regs_q[raddr_a];
    rdata_b = (raddr_b == REG_ZERO) ? '0 : regs_q[raddr_b];
    rdata_c = (raddr_c == REG_ZERO) ? '0 : regs_q[raddr_c];
  end

endmodule

// File: rtl/wb_regfile_unit.sv
// Write-back stage: result mux, commit to register file, same-cycle bypass to ID reads, retired-write counter.
// Reads and bypass are 0-cycle; commits land on the clock edge. cpu_en low freezes all state and disables bypass.
module wb_regfile_unit
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_en,
  input  logic                  wb_ifWriteRegsFile,
  input  logic                  wb_memOutOrAluOutWriteBackToRegFile,
  input  logic [REG_ADDR_W-1:0] wb_registerWriteAddress,
  input  logic [XLEN-1:0]       wb_memoryData,
  input  logic [XLEN-1:0]       wb_aluOutput,
  input  logic [REG_ADDR_W-1:0] id_rs1Addr,
  input  logic [REG_ADDR_W-1:0] id_rs2Addr,
  output logic [XLEN-1:0]       id_rs1Data,
  output logic [XLEN-1:0]       id_rs2Data,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [XLEN-1:0]       dbg_data,
  output logic [XLEN-1:0]       wb_writeData,
  output logic [CNT_W-1:0]      wb_retireCount
);

  logic            commit;
  logic [XLEN-1:0] rf_rs1;
  logic [XLEN-1:0] rf_rs2;
  logic [CNT_W-1:0] retire_cnt_q;
  logic [CNT_W-1:0] retire_cnt_d;

  assign wb_writeData = wb_memOutOrAluOutWriteBackToRegFile ? wb_memoryData : wb_aluOutput;
  assign commit       = commit_ok(cpu_en, wb_ifWriteRegsFile, wb_registerWriteAddress);

  regfile_2r1w u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (commit),
    .waddr   (wb_registerWriteAddress),
    .wdata   (wb_writeData),
    .raddr_a (id_rs1Addr),
    .raddr_b (id_rs2Addr),
    .raddr_c (dbg_addr),
    .rdata_a (rf_rs1),
    .rdata_b (rf_rs2),
    .rdata_c (dbg_data)
  );

  // commit already excludes r0, so the bypass can never leak a nonzero value onto address 0.
  always_comb begin
    id_rs1Data = rf_rs1;
    id_rs2Data = rf_rs2;
    if (commit && (id_rs1Addr == wb_registerWriteAddress)) begin
      id_rs1Data = wb_writeData;
    end
    if (commit && (id_rs2Addr == wb_registerWriteAddress)) begin
      id_rs2Data = wb_writeData;
    end
  end

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (commit) begin
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign wb_retireCount = retire_cnt_q;

endmodule

// File: tb/tb_wb_regfile_unit.sv
// Randomized bench for wb_regfile_unit against an array/counter reference model, plus directed literal cases.
module tb_wb_regfile_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic        we;
  logic        sel;
  logic [4:0]  waddr;
  logic [31:0] mem;
  logic [31:0] alu;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  dbg;
  logic [31:0] id_rs1Data;
  logic [31:0] id_rs2Data;
  logic [31:0] dbg_data;
  logic [31:0] wb_writeData;
  logic [31:0] wb_retireCount;

  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;
  int          vectors;
  int          miscompares;
  bit          chk_en;

  always #5 clk = ~clk;

  wb_regfile_unit dut (
    .clk                                 (clk),
    .rst                                 (rst),
    .cpu_en                              (cpu_en),
    .wb_ifWriteRegsFile                  (we),
    .wb_memOutOrAluOutWriteBackToRegFile (sel),
    .wb_registerWriteAddress             (waddr),
    .wb_memoryData                       (mem),
    .wb_aluOutput                        (alu),
    .id_rs1Addr                          (rs1),
    .id_rs2Addr                          (rs2),
    .id_rs1Data                          (id_rs1Data),
    .id_rs2Data                          (id_rs2Data),
    .dbg_addr                            (dbg),
    .dbg_data                            (dbg_data),
    .wb_writeData                        (wb_writeData),
    .wb_retireCount                      (wb_retireCount)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_wd();
    return sel ? mem : alu;
  endfunction

  function automatic logic m_commit();
    return (cpu_en === 1'b1) && (we === 1'b1) && (waddr != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_commit() && a == waddr) return m_wd();
    return m_regs[a];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_cnt = 32'd0;
  endtask

  always @(posedge clk) begin
    if (rst === 1'b1 && m_commit()) begin
      m_regs[waddr] = m_wd();
      m_cnt = m_cnt + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("wb_writeData", wb_writeData, m_wd());
      check("id_rs1Data", id_rs1Data, m_read(rs1));
      check("id_rs2Data", id_rs2Data, m_read(rs2));
      check("dbg_data", dbg_data, (dbg == 5'd0) ? 32'd0 : m_regs[dbg]);
      check("wb_retireCount", wb_retireCount, m_cnt);
    end
  end

  task automatic drv(input logic en_i, input logic we_i, input logic sel_i, input logic [4:0] wa_i,
                     input logic [31:0] mem_i, input logic [31:0] alu_i,
                     input logic [4:0] r1_i, input logic [4:0] r2_i, input logic [4:0] dbg_i);
    cpu_en = en_i; we = we_i; sel = sel_i; waddr = wa_i;
    mem = mem_i; alu = alu_i; rs1 = r1_i; rs2 = r2_i; dbg = dbg_i;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rand_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      drv(($urandom % 8) != 0, 1'($urandom % 2), 1'($urandom % 2), wa, $urandom, $urandom,
          (($urandom % 3) == 0) ? wa : 5'($urandom_range(0, 31)),
          (($urandom % 3) == 0) ? wa : 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)));
      step();
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    chk_en = 1'b0;
    rst = 1'b0;
    m_clear();
    drv(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    #12;
    step();
    rst = 1'b1;
    chk_en = 1'b1;
    drv(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd4, 5'd17, 5'd31);
    #1;
    check("reset_rs1", id_rs1Data, 32'd0);
    check("reset_dbg", dbg_data, 32'd0);
    check("reset_count", wb_retireCount, 32'd0);

    // ALU write with same-cycle bypass, visible on debug port next cycle
    step();
    drv(1'b1, 1'b1, 1'b0, 5'd5, 32'd0, 32'hDEADBEEF, 5'd5, 5'd0, 5'd5);
    #1;
    check("alu_bypass_rs1", id_rs1Data, 32'hDEADBEEF);
    check("dbg_no_bypass", dbg_data, 32'd0);
    step();
    drv(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd5);
    #1;
    check("dbg_r5", dbg_data, 32'hDEADBEEF);
    check("count_1", wb_retireCount, 32'd1);

    // memory-data select
    step();
    drv(1'b1, 1'b1, 1'b1, 5'd7, 32'h12345678, 32'hFFFFFFFF, 5'd7, 5'd0, 5'd0);
    #1;
    check("mem_writeData", wb_writeData, 32'h12345678);
    check("mem_bypass_rs1", id_rs1Data, 32'h12345678);
    step();
    drv(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd7);
    #1;
    check("dbg_r7", dbg_data, 32'h12345678);
    check("count_2", wb_retireCount, 32'd2);

    // write to r0 is discarded
    step();
    drv(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 32'hAAAAAAAA, 5'd0, 5'd0, 5'd0);
    #1;
    check("r0_rs1", id_rs1Data, 32'd0);
    check("r0_rs2", id_rs2Data, 32'd0);
    check("r0_writeData", wb_writeData, 32'hAAAAAAAA);
    step();
    drv(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    #1;
    check("r0_dbg", dbg_data, 32'd0);
    check("r0_count", wb_retireCount, 32'd2);

    // stalled write neither commits nor bypasses
    step();
    drv(1'b1, 1'b1, 1'b0, 5'd3, 32'd0, 32'h33, 5'd0, 5'd0, 5'd0);
    step();
    drv(1'b0, 1'b1, 1'b0, 5'd3, 32'd0, 32'h55, 5'd3, 5'd3, 5'd3);
    #1;
    check("stall_rs1", id_rs1Data, 32'h33);
    check("stall_rs2", id_rs2Data, 32'h33);
    step();
    drv(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd3);
    #1;
    check("stall_dbg_r3", dbg_data, 32'h33);
    check("stall_count", wb_retireCount, 32'd3);

    // counter wrap, and both ports bypassing the same register
    step();
    force dut.retire_cnt_q = 32'hFFFFFFFF;
    m_cnt = 32'hFFFFFFFF;
    #1;
    release dut.retire_cnt_q;
    drv(1'b1, 1'b1, 1'b0, 5'd9, 32'd0, 32'hCAFEF00D, 5'd9, 5'd9, 5'd0);
    #1;
    check("preload_count", wb_retireCount, 32'hFFFFFFFF);
    check("dual_bypass_rs1", id_rs1Data, 32'hCAFEF00D);
    check("dual_bypass_rs2", id_rs2Data, 32'hCAFEF00D);
    step();
    drv(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd9);
    #1;
    check("wrap_count", wb_retireCount, 32'd0);
    check("wrap_dbg_r9", dbg_data, 32'hCAFEF00D);

    step();
    rand_cycles(1500);

    // asynchronous reset mid-run clears everything immediately
    drv(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd7, 5'd9);
    force dut.retire_cnt_q = 32'h00000010;
    m_cnt = 32'h00000010;
    #1;
    release dut.retire_cnt_q;
    #1;
    rst = 1'b0;
    m_clear();
    #1;
    check("async_rs1", id_rs1Data, 32'd0);
    check("async_rs2", id_rs2Data, 32'd0);
    check("async_dbg", dbg_data, 32'd0);
    check("async_count", wb_retireCount, 32'd0);
    step();
    step();
    rst = 1'b1;
    rand_cycles(300);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
